led_pwm_bank: RTL and testbench
===============================

LED_PWM_BANK -- requirements
Module: led_pwm_bank

Interface
REQ-001 SHALL have parameter pChannels, default 3, number of LED channels (1..8).
REQ-002 SHALL have parameter pPwmBits, default 8, PWM resolution in bits (1..8).
REQ-003 SHALL have parameter pPrescale, default 32'd256, clock cycles per PWM step (>=1).
REQ-004 SHALL have parameter pBaseAddr, default 32'h0000_1000, word-aligned base of the register window.
REQ-005 SHALL have parameter pActiveLow, default 1, 1 = LED lit when output low.
REQ-006 SHALL have iwClk, input, 1, the single clock.
REQ-007 SHALL have iwRst, input, 1, synchronous active-high reset.
REQ-008 SHALL have iwWriteAddr, input, 32, CPU write byte address.
REQ-009 SHALL have iwWriteData, input, 32, CPU write data.
REQ-010 SHALL have iwWstrb, input, 4, byte write strobes; any bit set = write this cycle.
REQ-011 SHALL have iwReadAddr, input, 32, CPU read byte address.
REQ-012 SHALL have owReadData, output, 32, registered read data.
REQ-013 SHALL have owLed, output, pChannels, LED drive, polarity per pActiveLow.

Function
REQ-014 SHALL map channel n control register CTRLn at pBaseAddr + 4*n; address bits [1:0] ignored.
REQ-015 SHALL define CTRLn fields: [7:0] duty (low pPwmBits used), [8] blink enable, [23:16] blink half-period, others read 0.
REQ-016 SHALL apply a write only to byte lanes whose strobe is set; writes outside the window are ignored.
REQ-017 SHALL store writes in a per-channel shadow register immediately; shadow is what reads return.
REQ-018 SHALL return owReadData one cycle after iwReadAddr (registered); 0 for addresses outside the window.
REQ-019 SHALL generate a one-cycle tick every pPrescale clocks from a prescale counter 0..pPrescale-1.
REQ-020 SHALL advance a shared pPwmBits-wide PWM counter by one per tick, wrapping 2^pPwmBits-1 -> 0.
REQ-021 SHALL copy shadow to active duty only on the tick at which the PWM counter wraps to 0 (glitch-free update).
REQ-022 SHALL, when a write and the wrap tick occur in the same cycle, load active from the newly written value.
REQ-023 SHALL assert channel lit = (active duty > PWM counter) AND blink phase on; duty 0 is always dark.
REQ-024 SHALL, with blink enabled, count PWM wraps per channel and toggle blink phase when the count reaches half-period, then clear the count.
REQ-025 SHALL treat half-period 0 as 1 when blink is enabled.
REQ-026 SHALL force blink phase on and clear the blink count in the cycle blink enable is written 0.
REQ-027 SHALL register owLed (one clock after lit is computed), inverted when pActiveLow = 1.

Reset
REQ-028 SHALL on iwRst clear all shadow/active registers, prescale, PWM and blink counters, set blink phase on.
REQ-029 SHALL drive owLed to the dark level (all 1s if pActiveLow, else all 0s) and owReadData to 0 during and after reset until first update.
REQ-030 SHALL give reset priority over any same-cycle write, discarding it.

Structure
REQ-031 SHALL place register offset, field bit positions and widths in package led_pwm_pkg.
REQ-032 SHALL instantiate one sub-module led_pwm_channel per channel (shadow, active, blink state, lit output); prescaler and PWM counter stay in led_pwm_bank.

Verification
REQ-033 SHALL cover reset: pActiveLow=1, after reset owLed = 3'b111, read CTRL0 -> 0.
REQ-034 SHALL cover duty: pPrescale=1, write CTRL1=0x80 -> owLed[1] low exactly 128 of 256 cycles per PWM period after next wrap.
REQ-035 SHALL cover byte strobes: write 0xFFFFFFFF with iwWstrb=4'b0001 to CTRL0 -> read returns 0x000000FF.
REQ-036 SHALL cover deferred update: write duty mid-period -> owLed unchanged until PWM counter wraps; write on wrap cycle -> takes effect that period.
REQ-037 SHALL cover blink: CTRL2=0x0002_01FF -> owLed[2] alternates 2 PWM periods PWM-active, 2 periods dark; half-period 0 -> alternates every period.
REQ-038 SHALL cover out-of-window write at pBaseAddr+4*pChannels and reset asserted mid-write -> no register changes.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared register layout for the LED PWM bank: CTRLn offsets, field positions and widths.
// The packing helper gives one definition of how a CTRL word reads back.
package led_pwm_pkg;

    localparam int cCtrlStride = 4;
    localparam int cDutyLsb    = 0;
    localparam int cDutyWidth  = 8;
    localparam int cBlinkEnBit = 8;
    localparam int cHalfLsb    = 16;
    localparam int cHalfWidth  = 8;

    typedef struct packed {
        logic [cHalfWidth-1:0] halfPeriod;
        logic                  blinkEn;
        logic [cDutyWidth-1:0] duty;
    } tCtrl;

    // Undefined CTRL bits always read back as zero.
    function automatic logic [31:0] packCtrl(input tCtrl c);
        logic [31:0] w;
        w = '0;
        w[cDutyLsb +: cDutyWidth] = c.duty;
        w[cBlinkEnBit]            = c.blinkEn;
        w[cHalfLsb +: cHalfWidth] = c.halfPeriod;
        return w;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: CTRL shadow register, wrap-synchronised active duty, blink phase
// and the combinational lit decision against the shared PWM counter.
module led_pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int pPwmBits = 8
) (
    input  logic                iwClk,
    input  logic                iwRst,
    input  logic                iwWrEn,
    input  logic [3:0]          iwWstrb,
    input  logic [31:0]         iwWriteData,
    input  logic                iwWrapTick,
    input  logic [pPwmBits-1:0] iwPwmCnt,
    output logic [31:0]         owCtrl,
    output logic                owLit
);

    tCtrl                  shadow;
    tCtrl                  shadowNext;
    logic [pPwmBits-1:0]   active;
    logic [cHalfWidth-1:0] blinkCnt;
    logic                  blinkPhase;
    logic [cHalfWidth-1:0] halfEff;
    logic [cHalfWidth:0]   blinkCntInc;
    logic                  blinkReached;
    logic                  blinkClear;
    logic                  unusedBits;

    always_comb begin
        shadowNext = shadow;
        if (iwWrEn) begin
            if (iwWstrb[0]) shadowNext.duty       = iwWriteData[cDutyLsb +: cDutyWidth];
            if (iwWstrb[1]) shadowNext.blinkEn    = iwWriteData[cBlinkEnBit];
            if (iwWstrb[2]) shadowNext.halfPeriod = iwWriteData[cHalfLsb +: cHalfWidth];
        end
    end

    assign blinkClear   = iwWrEn && iwWstrb[1] && !iwWriteData[cBlinkEnBit];
    assign halfEff      = (shadow.halfPeriod == '0) ? cHalfWidth'(1) : shadow.halfPeriod;
    assign blinkCntInc  = {1'b0, blinkCnt} + (cHalfWidth + 1)'(1);
    assign blinkReached = blinkCntInc >= {1'b0, halfEff};

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            shadow     <= '0;
            active     <= '0;
            blinkCnt   <= '0;
            blinkPhase <= 1'b1;
        end else begin
            shadow <= shadowNext;
            // Loading from shadowNext lets a write on the wrap cycle take effect this period.
            if (iwWrapTick) active <= shadowNext.duty[pPwmBits-1:0];
            if (blinkClear) begin
                blinkPhase <= 1'b1;
                blinkCnt   <= '0;
            end else if (iwWrapTick && shadow.blinkEn) begin
                if (blinkReached) begin
                    blinkPhase <= ~blinkPhase;
                    blinkCnt   <= '0;
                end else begin
                    blinkCnt <= blinkCntInc[cHalfWidth-1:0];
                end
            end
        end
    end

    assign owLit      = (active > iwPwmCnt) && blinkPhase;
    assign owCtrl     = packCtrl(shadow);
    assign unusedBits = ^{iwWstrb[3], iwWriteData[31:24], iwWriteData[15:9]};

endmodule

// File: rtl/led_pwm_bank.sv
// Bank of PWM-dimmed LED channels behind a small CPU register window.
// Prescaler and shared PWM counter live here; per-channel state lives in led_pwm_channel.
module led_pwm_bank
    import led_pwm_pkg::*;
#(
    parameter int          pChannels  = 3,
    parameter int          pPwmBits   = 8,
    parameter logic [31:0] pPrescale  = 32'd256,
    parameter logic [31:0] pBaseAddr  = 32'h0000_1000,
    parameter int          pActiveLow = 1
) (
    input  logic                 iwClk,
    input  logic                 iwRst,
    input  logic [31:0]          iwWriteAddr,
    input  logic [31:0]          iwWriteData,
    input  logic [3:0]           iwWstrb,
    input  logic [31:0]          iwReadAddr,
    output logic [31:0]          owReadData,
    output logic [pChannels-1:0] owLed
);

    localparam logic [pChannels-1:0] cDark = (pActiveLow != 0) ? '1 : '0;

    logic [31:0]          preCnt;
    logic                 tick;
    logic [pPwmBits-1:0]  pwmCnt;
    logic                 wrapTick;
    logic [31:0]          wrOff;
    logic [31:0]          wrWord;
    logic                 wrHit;
    logic [31:0]          rdOff;
    logic [31:0]          rdWord;
    logic                 rdHit;
    logic [31:0]          rdMux;
    logic [31:0]          ctrlWord [pChannels];
    logic [pChannels-1:0] lit;
    logic                 unusedBits;

    assign tick     = (preCnt == pPrescale - 32'd1);
    assign wrapTick = tick && (pwmCnt == '1);

    // Byte address bits [1:0] are ignored; word index selects the channel.
    assign wrOff  = iwWriteAddr - pBaseAddr;
    assign wrWord = {2'b00, wrOff[31:2]};
    assign wrHit  = (iwWriteAddr >= pBaseAddr) && (wrWord < 32'(pChannels)) && (|iwWstrb);
    assign rdOff  = iwReadAddr - pBaseAddr;
    assign rdWord = {2'b00, rdOff[31:2]};
    assign rdHit  = (iwReadAddr >= pBaseAddr) && (rdWord < 32'(pChannels));

    for (genvar gi = 0; gi < pChannels; gi++) begin : gChannel
        led_pwm_channel #(
            .pPwmBits(pPwmBits)
        ) uChannel (
            .iwClk      (iwClk),
            .iwRst      (iwRst),
            .iwWrEn     (wrHit && (wrWord == 32'(gi))),
            .iwWstrb    (iwWstrb),
            .iwWriteData(iwWriteData),
            .iwWrapTick (wrapTick),
            .iwPwmCnt   (pwmCnt),
            .owCtrl     (ctrlWord[gi]),
            .owLit      (lit[gi])
        );
    end

    always_comb begin
        rdMux = '0;
        for (int i = 0; i < pChannels; i++) begin
            if (rdHit && (rdWord == 32'(i))) rdMux = ctrlWord[i];
        end
    end

    always_ff @(posedge iwClk) begin
        if (iwRst) begin
            preCnt     <= '0;
            pwmCnt     <= '0;
            owLed      <= cDark;
            owReadData <= '0;
        end else begin
            preCnt     <= tick ? '0 : preCnt + 32'd1;
            if (tick) pwmCnt <= pwmCnt + pPwmBits'(1);
            owLed      <= (pActiveLow != 0) ? ~lit : lit;
            owReadData <= rdMux;
        end
    end

    assign unusedBits = ^{wrOff[1:0], rdOff[1:0]};

endmodule

// File: tb/tb_led_pwm_bank.sv
// Directed self-checking bench for led_pwm_bank with pPrescale=1 so one PWM period is 256 clocks.
// tbPwm is an independent model of the shared PWM counter used to align stimulus and sampling.
module tb_led_pwm_bank;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] iwWriteAddr = '0;
    logic [31:0] iwWriteData = '0;
    logic [3:0]  iwWstrb = '0;
    logic [31:0] iwReadAddr = '0;
    logic [31:0] owReadData;
    logic [2:0]  owLed;

    int nCmp = 0;
    int nBad = 0;
    logic [7:0] tbPwm = '0;

    led_pwm_bank #(
        .pChannels (3),
        .pPwmBits  (8),
        .pPrescale (32'd1),
        .pBaseAddr (BASE),
        .pActiveLow(1)
    ) dut (
        .iwClk      (clk),
        .iwRst      (rst),
        .iwWriteAddr(iwWriteAddr),
        .iwWriteData(iwWriteData),
        .iwWstrb    (iwWstrb),
        .iwReadAddr (iwReadAddr),
        .owReadData (owReadData),
        .owLed      (owLed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tbPwm <= '0;
        else     tbPwm <= tbPwm + 8'd1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end at a falling edge.
    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        iwWriteAddr = a;
        iwWriteData = d;
        iwWstrb     = s;
        @(negedge clk);
        iwWstrb     = 4'b0000;
    endtask

    task automatic busRead(input logic [31:0] a, output logic [31:0] d);
        iwReadAddr = a;
        @(negedge clk);
        d = owReadData;
    endtask

    task automatic waitPwm(input logic [7:0] v);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tbPwm == v) begin
                ok = 1'b1;
                break;
            end
        end
        nCmp++;
        if (!ok) begin
            nBad++;
            $display("FAIL waitPwm: pwm count %0d not reached, at %0d", v, tbPwm);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int notDark;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nCmp++;
        if (owLed !== 3'b111) begin nBad++; $display("FAIL resetLed: got %b want 111", owLed); end
        nCmp++;
        if (owReadData !== 32'h0) begin nBad++; $display("FAIL resetRead: got %h want 0", owReadData); end
        rst = 1'b0;
        busRead(BASE, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL resetCtrl0: got %h want 0", d); end
        notDark = 0;
        for (int i = 0; i < 256; i++) begin
            if (owLed !== 3'b111) notDark++;
            @(negedge clk);
        end
        nCmp++;
        if (notDark != 0) begin nBad++; $display("FAIL resetDarkPeriod: got %0d lit samples want 0", notDark); end
    endtask

    task automatic test_byte_strobe();
        logic [31:0] d;
        doReset();
        busWrite(BASE, 32'hFFFF_FFFF, 4'b0001);
        busRead(BASE, d);
        nCmp++;
        if (d !== 32'h0000_00FF) begin nBad++; $display("FAIL strobeLane0: got %h want 000000ff", d); end
        busWrite(BASE + 32'd4, 32'hFFFF_FFFF, 4'b0100);
        busRead(BASE + 32'd4, d);
        nCmp++;
        if (d !== 32'h00FF_0000) begin nBad++; $display("FAIL strobeLane2: got %h want 00ff0000", d); end
        busWrite(BASE + 32'd7, 32'hFFFF_FFFF, 4'b1111);
        busRead(BASE + 32'd4, d);
        nCmp++;
        if (d !== 32'h00FF_01FF) begin nBad++; $display("FAIL strobeAllLanes: got %h want 00ff01ff", d); end
        busWrite(BASE + 32'd8, 32'h1234_5678, 4'b1000);
        busRead(BASE + 32'd8, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL strobeLane3: got %h want 0", d); end
        busWrite(BASE + 32'd8, 32'hABCD_1234, 4'b0011);
        busRead(BASE + 32'd8, d);
        nCmp++;
        if (d !== 32'h0000_0034) begin nBad++; $display("FAIL strobeLanes01: got %h want 00000034", d); end
    endtask

    task automatic test_duty();
        int lows1;
        int lows0;
        int shapeErr;
        doReset();
        busWrite(BASE + 32'd4, 32'h0000_0080, 4'b1111);
        waitPwm(8'd1);
        lows1 = 0;
        lows0 = 0;
        shapeErr = 0;
        for (int i = 0; i < 256; i++) begin
            if (owLed[1] === 1'b0) lows1++;
            if (owLed[0] === 1'b0) lows0++;
            if (owLed[1] !== ((i < 128) ? 1'b0 : 1'b1)) shapeErr++;
            @(negedge clk);
        end
        nCmp++;
        if (lows1 != 128) begin nBad++; $display("FAIL dutyLowCount: got %0d want 128", lows1); end
        nCmp++;
        if (shapeErr != 0) begin nBad++; $display("FAIL dutyShape: got %0d bad samples want 0", shapeErr); end
        nCmp++;
        if (lows0 != 0) begin nBad++; $display("FAIL dutyZeroDark: got %0d lit samples want 0", lows0); end
    endtask

    task automatic test_deferred();
        int holdErr;
        doReset();
        waitPwm(8'd100);
        busWrite(BASE, 32'h0000_00FF, 4'b0001);
        holdErr = 0;
        for (int i = 0; i < 600; i++) begin
            if (tbPwm == 8'd1) break;
            if (owLed[0] !== 1'b1) holdErr++;
            @(negedge clk);
        end
        nCmp++;
        if (holdErr != 0) begin nBad++; $display("FAIL deferredHold: got %0d early lit samples want 0", holdErr); end
        nCmp++;
        if (owLed[0] !== 1'b0) begin nBad++; $display("FAIL deferredApply: got %b want 0", owLed[0]); end
        waitPwm(8'd255);
        busWrite(BASE + 32'd4, 32'h0000_0040, 4'b0001);
        waitPwm(8'd1);
        nCmp++;
        if (owLed[1] !== 1'b0) begin nBad++; $display("FAIL wrapWriteFirst: got %b want 0", owLed[1]); end
        waitPwm(8'h40);
        nCmp++;
        if (owLed[1] !== 1'b0) begin nBad++; $display("FAIL wrapWriteLastLit: got %b want 0", owLed[1]); end
        waitPwm(8'h41);
        nCmp++;
        if (owLed[1] !== 1'b1) begin nBad++; $display("FAIL wrapWriteFirstDark: got %b want 1", owLed[1]); end
    endtask

    task automatic test_blink();
        logic expTwo [8];
        logic expOne [4];
        expTwo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        expOne = '{1'b1, 1'b0, 1'b1, 1'b0};
        doReset();
        waitPwm(8'd10);
        busWrite(BASE + 32'd8, 32'h0002_01FF, 4'b1111);
        for (int p = 0; p < 8; p++) begin
            waitPwm(8'd1);
            nCmp++;
            if (owLed[2] !== expTwo[p]) begin
                nBad++;
                $display("FAIL blinkHalf2 period %0d: got %b want %b", p, owLed[2], expTwo[p]);
            end
        end
        busWrite(BASE + 32'd8, 32'h0000_00FF, 4'b1111);
        busWrite(BASE + 32'd8, 32'h0000_01FF, 4'b1111);
        for (int p = 0; p < 4; p++) begin
            waitPwm(8'd1);
            nCmp++;
            if (owLed[2] !== expOne[p]) begin
                nBad++;
                $display("FAIL blinkHalf0 period %0d: got %b want %b", p, owLed[2], expOne[p]);
            end
        end
    endtask

    task automatic test_window();
        logic [31:0] d;
        doReset();
        busWrite(BASE, 32'h0000_0055, 4'b1111);
        busWrite(BASE + 32'd12, 32'hFFFF_FFFF, 4'b1111);
        busWrite(BASE - 32'd4, 32'hFFFF_FFFF, 4'b1111);
        busRead(BASE, d);
        nCmp++;
        if (d !== 32'h0000_0055) begin nBad++; $display("FAIL windowCtrl0: got %h want 00000055", d); end
        busRead(BASE + 32'd4, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL windowCtrl1: got %h want 0", d); end
        busRead(BASE + 32'd8, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL windowCtrl2: got %h want 0", d); end
        busRead(BASE + 32'd12, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL windowReadOutside: got %h want 0", d); end
        rst         = 1'b1;
        iwWriteAddr = BASE + 32'd4;
        iwWriteData = 32'h0000_0077;
        iwWstrb     = 4'b1111;
        @(negedge clk);
        iwWstrb = 4'b0000;
        repeat (2) @(negedge clk);
        nCmp++;
        if (owLed !== 3'b111) begin nBad++; $display("FAIL rstWriteLed: got %b want 111", owLed); end
        rst = 1'b0;
        busRead(BASE + 32'd4, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL rstWriteCtrl1: got %h want 0", d); end
        busRead(BASE, d);
        nCmp++;
        if (d !== 32'h0) begin nBad++; $display("FAIL rstWriteCtrl0: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_byte_strobe();
        test_duty();
        test_deferred();
        test_blink();
        test_window();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
